ex_mem: RTL and testbench

Execute-to-memory pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It takes the EX-stage results (ALU result, store data, CSR write data, memory op, trap bus) and presents them to the MEM stage. It can absorb one beat of MEM back-pressure without combinational ready paths, and it supports flush. It sits between the EX datapath and the LSU/MEM stage, carrying the control fields that the ID/EX register delivered to EX.

---
 rtl/ex_mem_pkg.sv | 38 +++
 rtl/ex_mem_skid_buf.sv | 105 ++++++++++
 rtl/ex_mem.sv | 81 ++++++++
 tb/tb_ex_mem.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, payload layout and skid-buffer state names for
// the EX/MEM pipeline register.
//   - Field widths replace the old sysconfig.v macros.
//   - ex_mem_payload_t is the concatenated payload.
//   - EX_MEM_BUS_LEN is the payload width.
//   - skid_state_e names the {main_v, skid_v} occupancy.
package ex_mem_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned INST_LEN          = 32;
  localparam int unsigned REG_ADDRWIDTH     = 5;
  localparam int unsigned CSR_REG_ADDRWIDTH = 12;
  localparam int unsigned MEMOP_LEN         = 5;
  localparam int unsigned TRAP_BUS          = 8;

  // Field order defines the bit-slice layout of the concatenated bus.
  typedef struct packed {
    logic [XLEN-1:0]              pc;
    logic [INST_LEN-1:0]          inst_data;
    logic [REG_ADDRWIDTH-1:0]     rd_idx;
    logic [XLEN-1:0]              exu_result;
    logic [XLEN-1:0]              rs2_data;
    logic [CSR_REG_ADDRWIDTH-1:0] csr_idx;
    logic [XLEN-1:0]              csr_wdata;
    logic [MEMOP_LEN-1:0]         mem_op;
    logic [TRAP_BUS-1:0]          trap_bus;
  } ex_mem_payload_t;

  localparam int unsigned EX_MEM_BUS_LEN = $bits(ex_mem_payload_t);

  // Encoding is {main_v, skid_v}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/ex_mem_skid_buf.sv
// skid_buf: generic valid/ready pipeline stage with a one-entry skid buffer.
// ready_o depends only on registered state, so there is no combinational path
// from ready_i.
// Ports:
//   - clk, rst: clock and synchronous active-high reset.
//   - flush_i: drops all held beats.
//   - valid_i, ready_o, data_i: upstream handshake.
//   - valid_o, ready_i, data_o: downstream handshake.
module skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q;
  logic             main_en, skid_en;
  logic             accept, leave;
  skid_state_e      state;

  assign ready_o = ~skid_v_q;
  assign valid_o = main_v_q;
  assign data_o  = main_q;

  assign accept = valid_i & ready_o;
  assign leave  = main_v_q & ready_i;

  always_comb begin
    unique case ({main_v_q, skid_v_q})
      2'b00:   state = SKID_EMPTY;
      2'b10:   state = SKID_ONE;
      default: state = SKID_FULL;
    endcase
  end

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = data_i;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    unique case (state)
      SKID_EMPTY: begin
        if (accept) begin
          main_v_d = 1'b1;
          main_en  = 1'b1;
        end
      end
      SKID_ONE: begin
        if (accept && !leave) begin
          skid_v_d = 1'b1;
          skid_en  = 1'b1;
        end else if (accept && leave) begin
          main_en = 1'b1;
        end else if (leave) begin
          main_v_d = 1'b0;
        end
      end
      SKID_FULL: begin
        // The overflow beat moves up when the head leaves.
        if (leave) begin
          main_d   = skid_q;
          main_en  = 1'b1;
          skid_v_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Flush wins over everything. Payload stays untouched because only the
    // valid bits matter once they are cleared.
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_en  = 1'b0;
      skid_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      if (main_en) main_q <= main_d;
      if (skid_en) skid_q <= data_i;
    end
  end

endmodule

// File: rtl/ex_mem.sv
// ex_mem: EX-to-MEM pipeline stage register.
// The stage packs the EX results into one payload bus and passes it through a
// skid_buf. It can absorb one beat of MEM back-pressure and it supports flush.
// Ports:
//   - clk, rst: clock and synchronous active-high reset.
//   - valid_ex_mem_i, ready_ex_mem_o: EX-side handshake.
//   - *_ex_mem_i: EX payload fields.
//   - flush_ex_mem_i: discards all held beats.
//   - valid_ex_mem_o, ready_ex_mem_i: MEM-side handshake.
//   - *_ex_mem_o: payload fields presented to MEM.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_ex_mem_i,
  output logic                         ready_ex_mem_o,
  input  logic [XLEN-1:0]              pc_ex_mem_i,
  input  logic [INST_LEN-1:0]          inst_data_ex_mem_i,
  input  logic [REG_ADDRWIDTH-1:0]     rd_idx_ex_mem_i,
  input  logic [XLEN-1:0]              exu_result_ex_mem_i,
  input  logic [XLEN-1:0]              rs2_data_ex_mem_i,
  input  logic [CSR_REG_ADDRWIDTH-1:0] csr_idx_ex_mem_i,
  input  logic [XLEN-1:0]              csr_wdata_ex_mem_i,
  input  logic [MEMOP_LEN-1:0]         mem_op_ex_mem_i,
  input  logic [TRAP_BUS-1:0]          trap_bus_ex_mem_i,
  input  logic                         flush_ex_mem_i,
  output logic                         valid_ex_mem_o,
  input  logic                         ready_ex_mem_i,
  output logic [XLEN-1:0]              pc_ex_mem_o,
  output logic [INST_LEN-1:0]          inst_data_ex_mem_o,
  output logic [REG_ADDRWIDTH-1:0]     rd_idx_ex_mem_o,
  output logic [XLEN-1:0]              exu_result_ex_mem_o,
  output logic [XLEN-1:0]              rs2_data_ex_mem_o,
  output logic [CSR_REG_ADDRWIDTH-1:0] csr_idx_ex_mem_o,
  output logic [XLEN-1:0]              csr_wdata_ex_mem_o,
  output logic [MEMOP_LEN-1:0]         mem_op_ex_mem_o,
  output logic [TRAP_BUS-1:0]          trap_bus_ex_mem_o
);

  ex_mem_payload_t in_pl;
  ex_mem_payload_t out_pl;

  always_comb begin
    in_pl            = '0;
    in_pl.pc         = pc_ex_mem_i;
    in_pl.inst_data  = inst_data_ex_mem_i;
    in_pl.rd_idx     = rd_idx_ex_mem_i;
    in_pl.exu_result = exu_result_ex_mem_i;
    in_pl.rs2_data   = rs2_data_ex_mem_i;
    in_pl.csr_idx    = csr_idx_ex_mem_i;
    in_pl.csr_wdata  = csr_wdata_ex_mem_i;
    in_pl.mem_op     = mem_op_ex_mem_i;
    in_pl.trap_bus   = trap_bus_ex_mem_i;
  end

  skid_buf #(
    .WIDTH(EX_MEM_BUS_LEN)
  ) u_skid_buf (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush_ex_mem_i),
    .valid_i(valid_ex_mem_i),
    .ready_o(ready_ex_mem_o),
    .data_i (in_pl),
    .valid_o(valid_ex_mem_o),
    .ready_i(ready_ex_mem_i),
    .data_o (out_pl)
  );

  assign pc_ex_mem_o         = out_pl.pc;
  assign inst_data_ex_mem_o  = out_pl.inst_data;
  assign rd_idx_ex_mem_o     = out_pl.rd_idx;
  assign exu_result_ex_mem_o = out_pl.exu_result;
  assign rs2_data_ex_mem_o   = out_pl.rs2_data;
  assign csr_idx_ex_mem_o    = out_pl.csr_idx;
  assign csr_wdata_ex_mem_o  = out_pl.csr_wdata;
  assign mem_op_ex_mem_o     = out_pl.mem_op;
  assign trap_bus_ex_mem_o   = out_pl.trap_bus;

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: self-checking bench for ex_mem.
// The reference model is a two-deep FIFO queue:
//   - ready  = fewer than two entries are held.
//   - valid  = the queue is not empty.
//   - output = the head of the queue.
//   - flush and reset empty the queue.
module tb_ex_mem;
  import ex_mem_pkg::*;

  logic clk;
  logic rst;
  logic valid_i, ready_i, flush_i;
  logic ready_o, valid_o;
  ex_mem_payload_t din;
  ex_mem_payload_t dout;

  logic [XLEN-1:0]              pc_o, exu_o, rs2_o, csrw_o;
  logic [INST_LEN-1:0]          inst_o;
  logic [REG_ADDRWIDTH-1:0]     rd_o;
  logic [CSR_REG_ADDRWIDTH-1:0] csri_o;
  logic [MEMOP_LEN-1:0]         memop_o;
  logic [TRAP_BUS-1:0]          trap_o;

  int unsigned tests_run;
  int unsigned tests_failed;

  ex_mem_payload_t exp_q[$];

  ex_mem dut (
    .clk                (clk),
    .rst                (rst),
    .valid_ex_mem_i     (valid_i),
    .ready_ex_mem_o     (ready_o),
    .pc_ex_mem_i        (din.pc),
    .inst_data_ex_mem_i (din.inst_data),
    .rd_idx_ex_mem_i    (din.rd_idx),
    .exu_result_ex_mem_i(din.exu_result),
    .rs2_data_ex_mem_i  (din.rs2_data),
    .csr_idx_ex_mem_i   (din.csr_idx),
    .csr_wdata_ex_mem_i (din.csr_wdata),
    .mem_op_ex_mem_i    (din.mem_op),
    .trap_bus_ex_mem_i  (din.trap_bus),
    .flush_ex_mem_i     (flush_i),
    .valid_ex_mem_o     (valid_o),
    .ready_ex_mem_i     (ready_i),
    .pc_ex_mem_o        (pc_o),
    .inst_data_ex_mem_o (inst_o),
    .rd_idx_ex_mem_o    (rd_o),
    .exu_result_ex_mem_o(exu_o),
    .rs2_data_ex_mem_o  (rs2_o),
    .csr_idx_ex_mem_o   (csri_o),
    .csr_wdata_ex_mem_o (csrw_o),
    .mem_op_ex_mem_o    (memop_o),
    .trap_bus_ex_mem_o  (trap_o)
  );

  assign dout = {pc_o, inst_o, rd_o, exu_o, rs2_o, csri_o, csrw_o, memop_o, trap_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_mem_payload_t mk(input logic [XLEN-1:0] pc);
    logic [EX_MEM_BUS_LEN-1:0] v;
    ex_mem_payload_t p;
    for (int i = 0; i < int'(EX_MEM_BUS_LEN); i++) v[i] = 1'($urandom_range(1, 0));
    p = ex_mem_payload_t'(v);
    p.pc = pc;
    return p;
  endfunction

  // One clock of stimulus. It is entered and left 1 time unit after a rising
  // edge, and it advances the reference queue by that edge's handshakes.
  task automatic cycle(input logic v, input logic r, input logic f,
                       input ex_mem_payload_t p);
    logic acc, lv;
    valid_i = v;
    ready_i = r;
    flush_i = f;
    din     = p;
    acc = v && (exp_q.size() < 2);
    lv  = r && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (f) exp_q.delete();
    else begin
      if (lv) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(p);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    din     = mk(32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    // Put junk on the inputs during reset; the outputs must still come up clean.
    rst = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b0;
    flush_i = 1'b0;
    din = mk(32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid got %b want 0", valid_o);
    end
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready got %b want 1", ready_o);
    end
    tests_run++;
    if (dout !== '0) begin
      tests_failed++;
      $display("FAIL reset_payload got %h want 0", dout);
    end
  endtask

  task automatic test_streaming();
    ex_mem_payload_t p;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      p = mk(32'h8000_0000 + 32'(4 * i));
      cycle(1'b1, 1'b1, 1'b0, p);
      tests_run++;
      if (valid_o !== 1'b1 || dout !== p) begin
        tests_failed++;
        $display("FAIL stream_beat%0d got v=%b pc=%h want v=1 pc=%h", i, valid_o, pc_o, p.pc);
      end
      tests_run++;
      if (ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready%0d got %b want 1", i, ready_o);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, mk(32'h0));
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_drain got v=%b want 0", valid_o);
    end
  endtask

  task automatic test_stall();
    ex_mem_payload_t p0, p1, p2;
    logic [XLEN-1:0] want_pc [3];
    do_reset();
    p0 = mk(32'h100);
    p1 = mk(32'h104);
    p2 = mk(32'h108);
    want_pc[0] = 32'h100;
    want_pc[1] = 32'h104;
    want_pc[2] = 32'h108;
    cycle(1'b1, 1'b0, 1'b0, p0);
    tests_run++;
    if (valid_o !== 1'b1 || pc_o !== 32'h100 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_first got v=%b pc=%h rdy=%b want v=1 pc=100 rdy=1", valid_o, pc_o, ready_o);
    end
    cycle(1'b1, 1'b0, 1'b0, p1);
    tests_run++;
    if (pc_o !== 32'h100 || ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_skid got pc=%h rdy=%b want pc=100 rdy=0", pc_o, ready_o);
    end
    cycle(1'b1, 1'b0, 1'b0, p2);
    tests_run++;
    if (pc_o !== 32'h100 || ready_o !== 1'b0 || dout !== p0) begin
      tests_failed++;
      $display("FAIL stall_hold got pc=%h rdy=%b want pc=100 rdy=0", pc_o, ready_o);
    end
    // Keep offering 0x108 and release MEM; the beats must drain in order.
    for (int i = 1; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, p2);
      tests_run++;
      if (valid_o !== 1'b1 || pc_o !== want_pc[i]) begin
        tests_failed++;
        $display("FAIL stall_drain%0d got v=%b pc=%h want v=1 pc=%h", i, valid_o, pc_o, want_pc[i]);
      end
    end
    tests_run++;
    if (dout !== p2) begin
      tests_failed++;
      $display("FAIL stall_last_payload got %h want %h", dout, p2);
    end
    cycle(1'b0, 1'b1, 1'b0, p2);
    tests_run++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_empty got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, mk(32'h200));
    cycle(1'b1, 1'b0, 1'b0, mk(32'h204));
    tests_run++;
    if (ready_o !== 1'b0 || pc_o !== 32'h200) begin
      tests_failed++;
      $display("FAIL flush_setup got rdy=%b pc=%h want rdy=0 pc=200", ready_o, pc_o);
    end
    cycle(1'b1, 1'b0, 1'b1, mk(32'h208));
    tests_run++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_clear got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, mk(32'h0));
      tests_run++;
      if (valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL flush_no_ghost%0d got v=%b pc=%h want v=0", i, valid_o, pc_o);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, mk(32'h300));
    cycle(1'b1, 1'b0, 1'b0, mk(32'h304));
    rst = 1'b1;
    valid_i = 1'b1;
    din = mk(32'h308);
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    tests_run++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ctrl got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o);
    end
    tests_run++;
    if (dout !== '0) begin
      tests_failed++;
      $display("FAIL midreset_payload got %h want 0", dout);
    end
  endtask

  task automatic test_random();
    logic v, r, f;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      v = 1'($urandom_range(1, 0));
      r = 1'($urandom_range(1, 0));
      f = ($urandom_range(63, 0) == 0);
      cycle(v, r, f, mk($urandom()));
      tests_run++;
      if (ready_o !== (exp_q.size() < 2)) begin
        tests_failed++;
        $display("FAIL rand_ready cyc%0d got %b want %b", i, ready_o, exp_q.size() < 2);
      end
      tests_run++;
      if (valid_o !== (exp_q.size() > 0)) begin
        tests_failed++;
        $display("FAIL rand_valid cyc%0d got %b want %b", i, valid_o, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        tests_run++;
        if (dout !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL rand_payload cyc%0d got %h want %h", i, dout, exp_q[0]);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    din     = '0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
